mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_if.sv | 28 ++
 rtl/mem_access_ctrl.sv | 67 ++++++
 2 files changed

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: requester handshake and memory-side bus of mem_access_ctrl
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_q,
    output req_ready, rsp_valid, rsp_rdata, busy, mem_address, mem_data, mem_wren
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_q,
    input  req_ready, rsp_valid, rsp_rdata, busy, mem_address, mem_data, mem_wren
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding request controller for a synchronous RAM with fixed read latency
module mem_access_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic               Clock,
  input  logic               Resetn,
  mem_access_ctrl_if.slave   bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WR      = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;
  localparam logic [2:0] LAT     = 3'(RD_LAT);

  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rsp_q, rsp_d;
  logic              accept, rd_done;

  // next state: accept only in IDLE, a write takes one edge, a read waits RD_LAT edges
  always_comb begin
    accept  = bus.req_valid && state_q == IDLE;
    rd_done = state_q == RD_WAIT && cnt_q == 3'd1;
    state_d = accept ? (bus.req_we ? WR : RD_WAIT)
            : (state_q == WR || rd_done || state_q == 2'd3) ? IDLE : state_q;
    cnt_d   = (accept && !bus.req_we) ? LAT : state_q == RD_WAIT ? cnt_q - 3'd1 : cnt_q;
    we_d    = accept ? bus.req_we : we_q;
    addr_d  = accept ? bus.req_addr : addr_q;
    data_d  = accept ? bus.req_wdata : data_q;
    rdata_d = rd_done ? bus.mem_q : rdata_q;
    rsp_d   = state_q == WR || rd_done;
  end

  // state registers, cleared asynchronously so an in-flight access is dropped without a response
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      rsp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      rsp_q   <= rsp_d;
    end
  end

  assign bus.req_ready   = state_q == IDLE;
  assign bus.busy        = state_q != IDLE;
  assign bus.rsp_valid   = rsp_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_data    = data_q;
  assign bus.mem_wren    = state_q == WR && we_q;
endmodule
